pipe_front_sequencer: RTL and testbench
=======================================

# pipe_front_sequencer

Front-end pipeline sequencer for the 5-stage MIPS core: the consumer side of the hazard detection handshake. It owns the PC register, the IF/ID register and the ID/EX control-field insertion. It turns single-cycle or multi-cycle stall requests into frozen PC/IF/ID cycles with bubbles injected into ID/EX, and applies branch flushes. Stall length is counted here, so the detection logic stays purely combinational.

## Interface
- RESET_PC, 32'h0000_0000: PC value after reset.
- CTRL_W, 10: width of the ID-stage control bundle forwarded to ID/EX.
- NOP_INSTR, 32'h0000_0000: instruction word loaded into IF/ID on a flush (sll $0,$0,0).
- clk  in  1  clock. Every register updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall_req  in  1  hazard present this cycle; sampled with stall_len.
- stall_len  in  2  total stall cycles requested (1..3); 0 is treated as 1.
- flush  in  1  branch taken, resolved in ID this cycle.
- branch_target  in  32  PC to load on flush.
- imem_instr  in  32  instruction fetched at the current pc.
- id_ctrl  in  CTRL_W  control bundle decoded for the IF/ID instruction.
- pc  out  32  current fetch PC.
- IF_ID_instr  out  32  IF/ID instruction.
- IF_ID_pc_plus4  out  32  IF/ID PC+4.
- IF_ID_valid  out  1  IF/ID holds a real instruction.
- ID_EX_ctrl  out  CTRL_W  registered control bundle; all zeros when a bubble is inserted.
- ID_EX_valid  out  1  ID/EX holds a real instruction.
- holding  out  1  combinational; the pipeline front is frozen this cycle.
- stall_total  out  16  saturating count of frozen cycles since reset.

## Operation
- Internal remaining counter, 2 bits: stall cycles still owed after the current one.
- holding = stall_req | (remaining != 0).
- Each cycle is resolved in exactly one of three modes, with priority rst > holding > flush > normal.
- Normal mode:
  - pc <= pc+4.
  - IF/ID <= {imem_instr, pc+4, valid=1}.
  - ID_EX_ctrl <= id_ctrl.
  - ID_EX_valid <= IF_ID_valid.
- Holding mode:
  - pc and all IF/ID fields keep their values.
  - ID_EX_ctrl <= 0 and ID_EX_valid <= 0 (bubble).
  - stall_total increments and saturates at 16'hFFFF.
- Flush mode (flush=1, holding=0):
  - pc <= branch_target.
  - IF/ID <= {NOP_INSTR, 0, valid=0}.
  - ID/EX takes id_ctrl normally, because the branch itself proceeds.
- flush during holding is dropped. The stalled branch re-resolves in ID once its operands are ready, and the hazard logic re-asserts flush then.
- Counter update at each edge:
  - stall_req=1: remaining <= max(remaining-1, L-1), where L = (stall_len==0) ? 1 : stall_len. Saturate-floor at 0 before the max.
  - stall_req=0 and remaining>0: remaining <= remaining-1.
  - Otherwise remaining stays 0.
- Reset, applied at any point including mid-stall:
  - pc=RESET_PC, remaining=0, stall_total=0.
  - IF_ID_instr=NOP_INSTR, IF_ID_pc_plus4=0, IF_ID_valid=0.
  - ID_EX_ctrl=0, ID_EX_valid=0.
  - holding then follows stall_req only.
- pc+4 is a 32-bit add; wrap at 32'hFFFF_FFFC -> 0 is legal and unflagged.

## Timing
- Zero-latency response: a stall_req asserted in cycle T freezes the edge that ends cycle T. holding rises combinationally in T.
- A request of length N, with no overlap, freezes exactly the edges ending cycles T..T+N-1. The first advancing edge ends cycle T+N.
- Request inputs need only be valid in cycle T. The counter owns the rest of the stall.
- Overlapping requests extend the stall to the later end. They never add to it.
- flush takes effect at the edge ending the cycle in which it is asserted. One IF/ID bubble results, and the fetch at branch_target is in IF the following cycle.
- Reset output values are visible at the first edge with rst=1.

## Structure
- Shared package pipe_pkg holds:
  - NOP_INSTR and the RESET_PC default.
  - The CTRL_W bundle field offsets (reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, alu_op[1:0], branch, jump).
  - A localparam MAX_STALL=3.
- One sub-module is natural: stall_counter. It holds remaining, the max/decrement logic and the stall_total saturating counter, and exports holding.

## Test plan
- Free run: rst for 2 cycles, then 4 cycles idle -> pc = 0,4,8,12,16; IF_ID_valid=1 from cycle 2 on; stall_total=0.
- Load-use: stall_req=1 with len=1 at pc=0x10 -> pc and IF_ID_instr hold for one edge, ID_EX_valid=0 for one cycle, pc=0x14 one cycle later, stall_total=1.
- Branch after load: len=2 at pc=0x20 with stall_req dropped the next cycle -> pc holds 0x20 across 2 edges, two ID/EX bubbles, stall_total=2.
- Overlap: len=3 at T, then len=1 at T+1 -> stall still ends after the edge of T+2 (3 frozen edges, not 4); len=3 at T+2 instead -> 5 frozen edges.
- Flush: flush=1 with branch_target=0x100 at pc=0x40 -> next pc=0x100, IF_ID_instr=0, IF_ID_valid=0. The same flush with stall_req=1 -> pc stays 0x40 and the flush is ignored.
- Reset mid-stall: len=3, rst asserted on the second frozen cycle -> pc=RESET_PC, remaining=0, stall_total=0; the pipeline advances on the first cycle after rst deasserts.

Source files
------------

// File: rtl/pipe_front_sequencer_pkg.sv
// Shared front-end definitions: reset/NOP constants, ID control bundle layout, sequencing modes.
package pipe_pkg;

    localparam int unsigned CTRL_W    = 10;
    localparam int unsigned MAX_STALL = 3;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Bit offsets of the ID control bundle forwarded to ID/EX.
    localparam int unsigned CTRL_REG_WRITE  = 0;
    localparam int unsigned CTRL_MEM_READ   = 1;
    localparam int unsigned CTRL_MEM_WRITE  = 2;
    localparam int unsigned CTRL_MEM_TO_REG = 3;
    localparam int unsigned CTRL_ALU_SRC    = 4;
    localparam int unsigned CTRL_REG_DST    = 5;
    localparam int unsigned CTRL_ALU_OP_LO  = 6;
    localparam int unsigned CTRL_ALU_OP_HI  = 7;
    localparam int unsigned CTRL_BRANCH     = 8;
    localparam int unsigned CTRL_JUMP       = 9;

    typedef struct packed {
        logic       jump;
        logic       branch;
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       mem_write;
        logic       mem_read;
        logic       reg_write;
    } id_ctrl_t;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_HOLD   = 2'd1,
        MODE_FLUSH  = 2'd2
    } seq_mode_e;

endpackage

// File: rtl/pipe_front_sequencer_if.sv
// Hazard handshake and front-end pipeline register bus.
interface pipe_front_sequencer_if
    import pipe_pkg::*;
();

    logic              stall_req;
    logic [1:0]        stall_len;
    logic              flush;
    logic [31:0]       branch_target;
    logic [31:0]       imem_instr;
    logic [CTRL_W-1:0] id_ctrl;

    logic [31:0]       pc;
    logic [31:0]       IF_ID_instr;
    logic [31:0]       IF_ID_pc_plus4;
    logic              IF_ID_valid;
    logic [CTRL_W-1:0] ID_EX_ctrl;
    logic              ID_EX_valid;
    logic              holding;
    logic [15:0]       stall_total;

    modport slave (
        input  stall_req, stall_len, flush, branch_target, imem_instr, id_ctrl,
        output pc, IF_ID_instr, IF_ID_pc_plus4, IF_ID_valid,
               ID_EX_ctrl, ID_EX_valid, holding, stall_total
    );

    modport master (
        output stall_req, stall_len, flush, branch_target, imem_instr, id_ctrl,
        input  pc, IF_ID_instr, IF_ID_pc_plus4, IF_ID_valid,
               ID_EX_ctrl, ID_EX_valid, holding, stall_total
    );

endinterface

// File: rtl/pipe_front_sequencer_stall_counter.sv
// Tracks owed stall cycles so the hazard detector can stay combinational.
module pipe_front_sequencer_stall_counter
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_req,
    input  logic [1:0]  stall_len,
    output logic        holding,
    output logic [15:0] stall_total
);

    logic [1:0] remaining;
    logic [1:0] rem_dec;
    logic [1:0] req_owed;
    logic [1:0] remaining_nxt;

    // Owed cycles after this one: overlapping requests extend to the later end, never add.
    always_comb begin
        rem_dec       = 2'd0;
        req_owed      = 2'd0;
        remaining_nxt = 2'd0;
        holding       = stall_req | (remaining != 2'd0);
        if (remaining != 2'd0) begin
            rem_dec = remaining - 2'd1;
        end
        if (stall_len != 2'd0) begin
            req_owed = stall_len - 2'd1;
        end
        if (stall_req) begin
            remaining_nxt = (rem_dec > req_owed) ? rem_dec : req_owed;
        end else begin
            remaining_nxt = rem_dec;
        end
    end

    // Remaining-cycle register and saturating frozen-cycle count.
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining   <= 2'd0;
            stall_total <= 16'd0;
        end else begin
            remaining <= remaining_nxt;
            if (holding && (stall_total != 16'hFFFF)) begin
                stall_total <= stall_total + 16'd1;
            end
        end
    end

endmodule

// File: rtl/pipe_front_sequencer.sv
// PC, IF/ID and ID/EX control insertion: freezes on stalls, injects bubbles, applies flushes.
module pipe_front_sequencer
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    pipe_front_sequencer_if.slave  bus
);

    seq_mode_e   mode;
    logic [31:0] pc_plus4;
    logic        holding;
    logic [15:0] stall_total;

    pipe_front_sequencer_stall_counter u_stall_counter (
        .clk         (clk),
        .rst         (rst),
        .stall_req   (bus.stall_req),
        .stall_len   (bus.stall_len),
        .holding     (holding),
        .stall_total (stall_total)
    );

    assign bus.holding     = holding;
    assign bus.stall_total = stall_total;

    // Resolve this cycle's mode; a flush arriving while frozen is dropped.
    always_comb begin
        mode     = MODE_NORMAL;
        pc_plus4 = bus.pc + 32'd4;
        if (holding) begin
            mode = MODE_HOLD;
        end else if (bus.flush) begin
            mode = MODE_FLUSH;
        end
    end

    // Front-end pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.pc             <= RESET_PC;
            bus.IF_ID_instr    <= NOP_INSTR;
            bus.IF_ID_pc_plus4 <= 32'd0;
            bus.IF_ID_valid    <= 1'b0;
            bus.ID_EX_ctrl     <= '0;
            bus.ID_EX_valid    <= 1'b0;
        end else begin
            case (mode)
                MODE_HOLD: begin
                    bus.ID_EX_ctrl  <= '0;
                    bus.ID_EX_valid <= 1'b0;
                end
                MODE_FLUSH: begin
                    bus.pc             <= bus.branch_target;
                    bus.IF_ID_instr    <= NOP_INSTR;
                    bus.IF_ID_pc_plus4 <= 32'd0;
                    bus.IF_ID_valid    <= 1'b0;
                    bus.ID_EX_ctrl     <= bus.id_ctrl;
                    bus.ID_EX_valid    <= bus.IF_ID_valid;
                end
                default: begin
                    bus.pc             <= pc_plus4;
                    bus.IF_ID_instr    <= bus.imem_instr;
                    bus.IF_ID_pc_plus4 <= pc_plus4;
                    bus.IF_ID_valid    <= 1'b1;
                    bus.ID_EX_ctrl     <= bus.id_ctrl;
                    bus.ID_EX_valid    <= bus.IF_ID_valid;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_front_sequencer.sv
// Directed checks of stall, overlap, flush and reset behaviour of the front-end sequencer.
module tb_pipe_front_sequencer;
    import pipe_pkg::*;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    pipe_front_sequencer_if bus ();

    pipe_front_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Instruction memory: word fetched at pc is 0x1000_0000 | pc.
    assign bus.imem_instr = 32'h1000_0000 | bus.pc;
    // Decoder stand-in: never zero, so bubbles are distinguishable.
    assign bus.id_ctrl = CTRL_W'(bus.IF_ID_pc_plus4 >> 2) | 10'h200;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.stall_req = 1'b0;
        bus.stall_len = 2'd0;
        bus.flush = 1'b0;
        bus.branch_target = 32'd0;

        // Reset for two cycles
        step();
        step();
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_ifid_instr", bus.IF_ID_instr, 32'h0);
        chk("rst_ifid_valid", 32'(bus.IF_ID_valid), 32'd0);
        chk("rst_idex_valid", 32'(bus.ID_EX_valid), 32'd0);
        chk("rst_idex_ctrl", 32'(bus.ID_EX_ctrl), 32'd0);
        chk("rst_total", 32'(bus.stall_total), 32'd0);
        chk("rst_holding", 32'(bus.holding), 32'd0);

        // Free run
        rst = 1'b0;
        step();
        chk("run1_pc", bus.pc, 32'h4);
        chk("run1_ifid_instr", bus.IF_ID_instr, 32'h1000_0000);
        chk("run1_ifid_pc4", bus.IF_ID_pc_plus4, 32'h4);
        chk("run1_ifid_valid", 32'(bus.IF_ID_valid), 32'd1);
        chk("run1_idex_ctrl", 32'(bus.ID_EX_ctrl), 32'h200);
        chk("run1_idex_valid", 32'(bus.ID_EX_valid), 32'd0);
        step();
        step();
        step();
        chk("run4_pc", bus.pc, 32'h10);
        chk("run4_idex_valid", 32'(bus.ID_EX_valid), 32'd1);
        chk("run4_total", 32'(bus.stall_total), 32'd0);

        // Load-use, single cycle
        bus.stall_req = 1'b1;
        bus.stall_len = 2'd1;
        #1;
        chk("lu_holding_comb", 32'(bus.holding), 32'd1);
        step();
        bus.stall_req = 1'b0;
        #1;
        chk("lu_pc_hold", bus.pc, 32'h10);
        chk("lu_instr_hold", bus.IF_ID_instr, 32'h1000_000C);
        chk("lu_bubble_valid", 32'(bus.ID_EX_valid), 32'd0);
        chk("lu_bubble_ctrl", 32'(bus.ID_EX_ctrl), 32'd0);
        chk("lu_total", 32'(bus.stall_total), 32'd1);
        chk("lu_holding_end", 32'(bus.holding), 32'd0);
        step();
        chk("lu_pc_adv", bus.pc, 32'h14);
        chk("lu_instr_adv", bus.IF_ID_instr, 32'h1000_0010);
        chk("lu_idex_valid", 32'(bus.ID_EX_valid), 32'd1);

        // Two-cycle stall, request present one cycle only
        step();
        step();
        step();
        chk("bl_pc_start", bus.pc, 32'h20);
        bus.stall_req = 1'b1;
        bus.stall_len = 2'd2;
        step();
        bus.stall_req = 1'b0;
        #1;
        chk("bl_pc_hold1", bus.pc, 32'h20);
        chk("bl_holding_cnt", 32'(bus.holding), 32'd1);
        chk("bl_bubble1", 32'(bus.ID_EX_valid), 32'd0);
        step();
        chk("bl_pc_hold2", bus.pc, 32'h20);
        chk("bl_bubble2", 32'(bus.ID_EX_valid), 32'd0);
        chk("bl_total", 32'(bus.stall_total), 32'd3);
        chk("bl_holding_end", 32'(bus.holding), 32'd0);
        step();
        chk("bl_pc_adv", bus.pc, 32'h24);

        // Overlap: len3 then len1 -> three frozen edges
        bus.stall_req = 1'b1;
        bus.stall_len = 2'd3;
        step();
        bus.stall_len = 2'd1;
        step();
        bus.stall_req = 1'b0;
        step();
        chk("ovA_pc_hold", bus.pc, 32'h24);
        chk("ovA_holding_end", 32'(bus.holding), 32'd0);
        step();
        chk("ovA_pc_adv", bus.pc, 32'h28);
        chk("ovA_total", 32'(bus.stall_total), 32'd6);

        // Overlap: len3 then len3 at T+2 -> five frozen edges
        bus.stall_req = 1'b1;
        bus.stall_len = 2'd3;
        step();
        bus.stall_req = 1'b0;
        step();
        bus.stall_req = 1'b1;
        bus.stall_len = 2'd3;
        step();
        bus.stall_req = 1'b0;
        step();
        chk("ovB_pc_hold4", bus.pc, 32'h28);
        chk("ovB_holding4", 32'(bus.holding), 32'd1);
        step();
        chk("ovB_pc_hold5", bus.pc, 32'h28);
        chk("ovB_holding_end", 32'(bus.holding), 32'd0);
        step();
        chk("ovB_pc_adv", bus.pc, 32'h2C);
        chk("ovB_total", 32'(bus.stall_total), 32'd11);

        // Advance to pc=0x40
        for (int i = 0; i < 5; i++) step();
        chk("fl_pc_start", bus.pc, 32'h40);

        // Flush during a stall is dropped
        bus.flush = 1'b1;
        bus.branch_target = 32'h100;
        bus.stall_req = 1'b1;
        bus.stall_len = 2'd1;
        step();
        bus.stall_req = 1'b0;
        #1;
        chk("fls_pc_hold", bus.pc, 32'h40);
        chk("fls_ifid_valid", 32'(bus.IF_ID_valid), 32'd1);
        chk("fls_total", 32'(bus.stall_total), 32'd12);

        // Flush taken
        step();
        bus.flush = 1'b0;
        #1;
        chk("fl_pc", bus.pc, 32'h100);
        chk("fl_ifid_instr", bus.IF_ID_instr, 32'h0);
        chk("fl_ifid_pc4", bus.IF_ID_pc_plus4, 32'h0);
        chk("fl_ifid_valid", 32'(bus.IF_ID_valid), 32'd0);
        chk("fl_idex_ctrl", 32'(bus.ID_EX_ctrl), 32'h210);
        chk("fl_idex_valid", 32'(bus.ID_EX_valid), 32'd1);
        step();
        chk("fl_pc_next", bus.pc, 32'h104);
        chk("fl_ifid_instr_next", bus.IF_ID_instr, 32'h1000_0100);
        chk("fl_idex_valid_next", 32'(bus.ID_EX_valid), 32'd0);
        chk("fl_idex_ctrl_next", 32'(bus.ID_EX_ctrl), 32'h200);

        // stall_len=0 behaves as length 1
        bus.stall_req = 1'b1;
        bus.stall_len = 2'd0;
        step();
        bus.stall_req = 1'b0;
        #1;
        chk("len0_pc_hold", bus.pc, 32'h104);
        chk("len0_holding_end", 32'(bus.holding), 32'd0);
        step();
        chk("len0_pc_adv", bus.pc, 32'h108);
        chk("len0_total", 32'(bus.stall_total), 32'd13);

        // Reset on the second frozen cycle of a len3 stall
        bus.stall_req = 1'b1;
        bus.stall_len = 2'd3;
        step();
        bus.stall_req = 1'b0;
        rst = 1'b1;
        step();
        chk("rms_pc", bus.pc, 32'h0);
        chk("rms_total", 32'(bus.stall_total), 32'd0);
        chk("rms_holding", 32'(bus.holding), 32'd0);
        chk("rms_ifid_valid", 32'(bus.IF_ID_valid), 32'd0);
        chk("rms_idex_valid", 32'(bus.ID_EX_valid), 32'd0);
        rst = 1'b0;
        step();
        chk("rms_pc_adv", bus.pc, 32'h4);

        // PC wrap at the top of the address space
        bus.flush = 1'b1;
        bus.branch_target = 32'hFFFF_FFFC;
        step();
        bus.flush = 1'b0;
        #1;
        chk("wrap_pc_top", bus.pc, 32'hFFFF_FFFC);
        step();
        chk("wrap_pc", bus.pc, 32'h0);
        chk("wrap_ifid_pc4", bus.IF_ID_pc_plus4, 32'h0);
        chk("wrap_ifid_instr", bus.IF_ID_instr, 32'hFFFF_FFFC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
